// File: rtl/miriscv_opcodes_pkg.sv
// miriscv_opcodes_pkg: RV32I major opcodes (instr[6:2]), decode-buffer entry type and legality helper.
package miriscv_opcodes_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] S_OPCODE_LOAD     = 5'b00000;
    localparam logic [4:0] S_OPCODE_MISC_MEM = 5'b00011;
    localparam logic [4:0] S_OPCODE_OPIMM    = 5'b00100;
    localparam logic [4:0] S_OPCODE_AUIPC    = 5'b00101;
    localparam logic [4:0] S_OPCODE_STORE    = 5'b01000;
    localparam logic [4:0] S_OPCODE_OP       = 5'b01100;
    localparam logic [4:0] S_OPCODE_LUI      = 5'b01101;
    localparam logic [4:0] S_OPCODE_BRANCH   = 5'b11000;
    localparam logic [4:0] S_OPCODE_JALR     = 5'b11001;
    localparam logic [4:0] S_OPCODE_JAL      = 5'b11011;
    localparam logic [4:0] S_OPCODE_SYSTEM   = 5'b11100;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } decbuf_entry_t;

    function automatic logic op_supported(input logic [4:0] op);
        return op inside {S_OPCODE_LUI, S_OPCODE_AUIPC, S_OPCODE_JAL, S_OPCODE_JALR,
                          S_OPCODE_BRANCH, S_OPCODE_LOAD, S_OPCODE_STORE, S_OPCODE_OPIMM,
                          S_OPCODE_OP, S_OPCODE_MISC_MEM, S_OPCODE_SYSTEM};
    endfunction

endpackage

// File: rtl/miriscv_imm.sv
// miriscv_imm: sign-extended immediate by instruction format; zero for opcodes without one.
module miriscv_imm
    import miriscv_opcodes_pkg::*;
(
    input  logic [XLEN-1:0] instr_i,
    output logic [XLEN-1:0] imm_o
);

    logic [XLEN-1:0] i;

    assign i = instr_i;

    always_comb begin
        imm_o = '0;
        case (i[6:2])
            S_OPCODE_OPIMM, S_OPCODE_LOAD, S_OPCODE_JALR:
                imm_o = {{20{i[31]}}, i[31:20]};
            S_OPCODE_STORE:
                imm_o = {{20{i[31]}}, i[31:25], i[11:7]};
            S_OPCODE_BRANCH:
                imm_o = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            S_OPCODE_LUI, S_OPCODE_AUIPC:
                imm_o = {i[31:12], 12'b0};
            S_OPCODE_JAL:
                imm_o = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end

endmodule

// File: rtl/miriscv_decode_buf.sv
// miriscv_decode_buf: fetch-to-decode instruction FIFO; immediate and illegal flag
// are computed on the write side so the decode side sees only registered values.
module miriscv_decode_buf
    import miriscv_opcodes_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            flush_i,
    input  logic            fetch_valid_i,
    input  logic [XLEN-1:0] fetch_instr_i,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            fetch_ready_o,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_instr_o,
    output logic [XLEN-1:0] dec_pc_o,
    output logic [XLEN-1:0] dec_imm_o,
    output logic            dec_illegal_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    decbuf_entry_t   mem [DEPTH];
    logic [CW-1:0]   count;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [XLEN-1:0] imm;
    logic            push;
    logic            pop;
    logic            illegal;

    miriscv_imm u_imm (
        .instr_i (fetch_instr_i),
        .imm_o   (imm)
    );

    // ready depends only on the registered count, never on dec_ready_i
    assign fetch_ready_o = count < FULL;
    assign dec_valid_o   = (count != '0) & ~flush_i;
    assign push          = fetch_valid_i & fetch_ready_o & ~flush_i;
    assign pop           = dec_valid_o & dec_ready_i;
    assign illegal       = ~((fetch_instr_i[1:0] == 2'b11) & op_supported(fetch_instr_i[6:2]));

    assign dec_instr_o   = mem[rd_ptr].instr;
    assign dec_pc_o      = mem[rd_ptr].pc;
    assign dec_imm_o     = mem[rd_ptr].imm;
    assign dec_illegal_o = mem[rd_ptr].illegal;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (flush_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) mem[wr_ptr] <= '{instr: fetch_instr_i, pc: fetch_pc_i, imm: imm, illegal: illegal};
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

endmodule
